// File: rtl/mux_7seg_corriente.sv
// Four-digit common-anode 7-seg scan driver for the current indicator.
// Ports: clk, reset, n_0C..n_3C digit codes, punto dp requests; an, seg, dp active low.
module mux_7seg_corriente #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] n_0C,
  input  logic [3:0] n_1C,
  input  logic [3:0] n_2C,
  input  logic [3:0] n_3C,
  input  logic [3:0] punto,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW =
    (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic {
    BLANK,
    DRIVE
  } phase_t;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [1:0]    idx_q;
  logic [1:0]    idx_d;
  logic [3:0]    sh_q [4];
  logic [3:0]    sh_dp_q;
  logic [3:0]    cur;
  logic          last;
  logic          snap;
  phase_t        phase;
  logic [3:0]    an_d;
  logic [6:0]    seg_d;
  logic          dp_d;

  function automatic logic [6:0] pattern(
    input logic [3:0] c
  );
    logic [6:0] p;
    unique case (c)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      4'd10:   p = 7'b1111111;
      default: p = 7'b0111111;
    endcase
    return p;
  endfunction

  always_comb begin
    last  = (cnt_q == CW'(REFRESH_DIV - 1));
    cnt_d = last ? '0 : cnt_q + 1'b1;
    idx_d = last ? idx_q + 2'd1 : idx_q;
    snap  = (idx_q == 2'd0) && (cnt_q == '0);
    phase = (cnt_q < CW'(BLANK_CYCLES)) ?
            BLANK : DRIVE;
    cur   = sh_q[idx_q];
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    unique case (phase)
      BLANK: begin
      end
      DRIVE: begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = pattern(cur);
        dp_d  = ~sh_dp_q[idx_q];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      sh_q[0] <= 4'd10;
      sh_q[1] <= 4'd10;
      sh_q[2] <= 4'd10;
      sh_q[3] <= 4'd10;
      sh_dp_q <= 4'b0000;
      an      <= 4'b1111;
      seg     <= 7'b1111111;
      dp      <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an    <= an_d;
      seg   <= seg_d;
      dp    <= dp_d;
      // Frame-start snapshot keeps a frame tear-free
      if (snap) begin
        sh_q[0] <= n_0C;
        sh_q[1] <= n_1C;
        sh_q[2] <= n_2C;
        sh_q[3] <= n_3C;
        sh_dp_q <= punto;
      end
    end
  end

endmodule

// File: tb/tb_mux_7seg_corriente.sv
// Bench for mux_7seg_corriente: segment table, directed scan, random vs model.
// Uses REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_mux_7seg_corriente;

  localparam int RD = 8;
  localparam int BC = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] n_0C, n_1C, n_2C, n_3C;
  logic [3:0] punto;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int tests = 0;
  int fails = 0;

  mux_7seg_corriente #(
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .n_0C (n_0C),
    .n_1C (n_1C),
    .n_2C (n_2C),
    .n_3C (n_3C),
    .punto(punto),
    .an   (an),
    .seg  (seg),
    .dp   (dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    logic [6:0] seg;
  } vec_t;

  vec_t       tbl [16];
  logic [6:0] lut [16];

  int         m_e;
  logic [3:0] m_sh [4];
  logic [3:0] m_dp;
  logic [3:0] m_an;
  logic [6:0] m_seg;
  logic       m_dpo;

  task automatic chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got=%h want=%h",
               nm, $time, got, exp);
    end
  endtask

  // Model in terms of edge number since release.
  task automatic model_edge();
    int p, s;
    m_an  = 4'hF;
    m_seg = 7'h7F;
    m_dpo = 1'b1;
    if (reset) begin
      m_e = 0;
      for (int i = 0; i < 4; i++)
        m_sh[i] = 4'd10;
      m_dp = 4'b0;
    end else begin
      m_e++;
      if ((m_e - 1) % (4 * RD) == 0) begin
        m_sh[0] = n_0C;
        m_sh[1] = n_1C;
        m_sh[2] = n_2C;
        m_sh[3] = n_3C;
        m_dp    = punto;
      end
      p = (m_e - 1) % RD;
      s = ((m_e - 1) / RD) % 4;
      if (p >= BC) begin
        m_an     = 4'hF;
        m_an[s]  = 1'b0;
        m_seg    = lut[m_sh[s]];
        m_dpo    = ~m_dp[s];
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_an", an, m_an);
    chk("model_seg", seg, m_seg);
    chk("model_dp", dp, m_dpo);
    chk("an_onecold", $countones(~an) <= 1, 1);
  endtask

  task automatic set_n(
    input logic [3:0] a3, a2, a1, a0
  );
    n_3C = a3;
    n_2C = a2;
    n_1C = a1;
    n_0C = a0;
  endtask

  initial begin
    logic [3:0] an_slot [4];
    int p, s, f;
    an_slot[0] = 4'b1110;
    an_slot[1] = 4'b1101;
    an_slot[2] = 4'b1011;
    an_slot[3] = 4'b0111;

    tbl[0]  = '{4'd0,  7'b1000000};
    tbl[1]  = '{4'd1,  7'b1111001};
    tbl[2]  = '{4'd2,  7'b0100100};
    tbl[3]  = '{4'd3,  7'b0110000};
    tbl[4]  = '{4'd4,  7'b0011001};
    tbl[5]  = '{4'd5,  7'b0010010};
    tbl[6]  = '{4'd6,  7'b0000010};
    tbl[7]  = '{4'd7,  7'b1111000};
    tbl[8]  = '{4'd8,  7'b0000000};
    tbl[9]  = '{4'd9,  7'b0010000};
    tbl[10] = '{4'd10, 7'b1111111};
    tbl[11] = '{4'd11, 7'b0111111};
    tbl[12] = '{4'd12, 7'b0111111};
    tbl[13] = '{4'd13, 7'b0111111};
    tbl[14] = '{4'd14, 7'b0111111};
    tbl[15] = '{4'd15, 7'b0111111};
    for (int i = 0; i < 16; i++)
      lut[tbl[i].code] = tbl[i].seg;

    m_e = 0;
    reset = 1'b1;
    set_n(4'($urandom), 4'($urandom),
          4'($urandom), 4'($urandom));
    punto = 4'($urandom);

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
    end

    @(negedge clk);
    reset = 1'b0;
    set_n(4'd1, 4'd0, 4'd0, 4'd10);
    punto = 4'b0000;
    for (int ed = 1; ed <= 96; ed++) begin
      if (ed == 11) n_3C = 4'd7;
      if (ed == 60) begin
        n_1C  = 4'd12;
        punto = 4'b0100;
      end
      tick();
      p = (ed - 1) % RD;
      s = ((ed - 1) / RD) % 4;
      f = (ed - 1) / (4 * RD);
      if (p < BC) begin
        chk("dir_blank_an", an, 4'hF);
        chk("dir_blank_seg", seg, 7'h7F);
      end else begin
        chk("dir_an", an, an_slot[s]);
        if (f == 0 && s == 0)
          chk("dir_seg_s0", seg, 7'h7F);
        if (f == 0 && (s == 1 || s == 2))
          chk("dir_seg_zero", seg, 7'h40);
        if (f == 0 && s == 3)
          chk("dir_seg_old", seg, 7'h79);
        if (f == 1 && s == 3)
          chk("dir_seg_new", seg, 7'h78);
        if (f == 2 && s == 1)
          chk("dir_seg_dash", seg, 7'h3F);
      end
      chk("dir_dp", dp,
          (f == 2 && s == 2 && p >= BC) ? 1'b0 : 1'b1);
      @(negedge clk);
    end

    reset = 1'b1;
    tick();
    @(negedge clk);
    reset = 1'b0;
    for (int ed = 1; ed <= 19; ed++) tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("midrst_an", an, 4'hF);
    chk("midrst_seg", seg, 7'h7F);
    chk("midrst_dp", dp, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("restart_b1", an, 4'hF);
    tick();
    chk("restart_b2", an, 4'hF);
    tick();
    chk("restart_an", an, 4'b1110);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        set_n(4'($urandom), 4'($urandom),
              4'($urandom), 4'($urandom));
        punto = 4'($urandom);
      end
      reset = ($urandom_range(199) == 0);
      tick();
    end

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reset = 1'b1;
      n_0C  = tbl[i].code;
      tick();
      @(negedge clk);
      reset = 1'b0;
      tick();
      tick();
      tick();
      chk("tbl_an", an, 4'b1110);
      chk($sformatf("tbl_seg%0d", i),
          seg, tbl[i].seg);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
